// File: rtl/uart_tx_pkg.sv
// Shared types for the UART transmitter and the downstream Tx-active decoder.
package uart_tx_pkg;

    localparam int DATA_BITS = 8;
    localparam int IDX_W     = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        s_IDLE         = 3'd0,
        s_TX_START_BIT = 3'd1,
        s_TX_DATA_BITS = 3'd2,
        s_TX_STOP_BIT  = 3'd3,
        s_CLEANUP      = 3'd4
    } state_t;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Per-bit cycle counter: emits a one-cycle tick when a bit period has elapsed.
module uart_tx_bit_timer #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Clr,
    input  logic i_En,
    output logic o_Tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            cnt_q <= '0;
        end else if (i_Clr) begin
            cnt_q <= '0;
        end else if (i_En) begin
            if (cnt_q == LAST) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign o_Tick = i_En && !i_Clr && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_fsm.sv
// 8N1 UART transmitter: accepts a byte in s_IDLE and serialises start, data (LSB first), stop.
module uart_tx_fsm #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_L,
    input  logic                  i_Tx_DV,
    input  logic [7:0]            i_Tx_Byte,
    output logic                  o_Tx_Serial,
    output logic                  o_Tx_Done,
    output uart_tx_pkg::state_t   o_State
);

    import uart_tx_pkg::*;

    generate
        if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
            $error("uart_tx_fsm: CLKS_PER_BIT must be within 2..65535");
        end
    endgenerate

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       byte_q, byte_d;
    logic             serial_q, serial_d;
    logic             done_q, done_d;

    logic             tmr_clr;
    logic             tmr_tick;

    // Timer only runs while a bit is on the line; any other state holds it at zero.
    assign tmr_clr = !((state_q == s_TX_START_BIT) ||
                       (state_q == s_TX_DATA_BITS) ||
                       (state_q == s_TX_STOP_BIT));

    uart_tx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Clr   (tmr_clr),
        .i_En    (!tmr_clr),
        .o_Tick  (tmr_tick)
    );

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q  <= s_IDLE;
            idx_q    <= '0;
            byte_q   <= '0;
            serial_q <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            byte_q   <= byte_d;
            serial_q <= serial_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        byte_d   = byte_q;
        serial_d = 1'b1;
        done_d   = 1'b0;

        case (state_q)
            s_IDLE: begin
                idx_d = '0;
                if (i_Tx_DV) begin
                    byte_d  = i_Tx_Byte;
                    state_d = s_TX_START_BIT;
                end
            end
            s_TX_START_BIT: begin
                if (tmr_tick) state_d = s_TX_DATA_BITS;
            end
            s_TX_DATA_BITS: begin
                if (tmr_tick) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = s_TX_STOP_BIT;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            s_TX_STOP_BIT: begin
                if (tmr_tick) state_d = s_CLEANUP;
            end
            s_CLEANUP: begin
                idx_d   = '0;
                state_d = s_IDLE;
            end
            default: begin
                idx_d   = '0;
                state_d = s_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so line, done and state update on one edge.
        case (state_d)
            s_TX_START_BIT: serial_d = 1'b0;
            s_TX_DATA_BITS: serial_d = byte_d[idx_d];
            s_CLEANUP:      done_d   = 1'b1;
            default:        serial_d = 1'b1;
        endcase
    end

    assign o_Tx_Serial = serial_q;
    assign o_Tx_Done   = done_q;
    assign o_State     = state_q;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Directed bench for uart_tx_fsm at CLKS_PER_BIT = 4, 2 and 87.
module tb_uart_tx_fsm;

    import uart_tx_pkg::*;

    localparam int C0 = 4;
    localparam int C1 = 2;
    localparam int C2 = 87;

    logic       clk;
    logic       rst_n;
    logic       dv   [3];
    logic [7:0] txb  [3];
    logic       ser  [3];
    logic       done [3];
    state_t     st   [3];

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int     cyc;
        logic   ser;
        logic   done;
        state_t st;
    } vec_t;

    vec_t vecs[$];

    uart_tx_fsm #(.CLKS_PER_BIT(C0)) u_dut4 (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Tx_DV(dv[0]), .i_Tx_Byte(txb[0]),
        .o_Tx_Serial(ser[0]), .o_Tx_Done(done[0]), .o_State(st[0])
    );

    uart_tx_fsm #(.CLKS_PER_BIT(C1)) u_dut2 (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Tx_DV(dv[1]), .i_Tx_Byte(txb[1]),
        .o_Tx_Serial(ser[1]), .o_Tx_Done(done[1]), .o_State(st[1])
    );

    uart_tx_fsm #(.CLKS_PER_BIT(C2)) u_dut87 (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Tx_DV(dv[2]), .i_Tx_Byte(txb[2]),
        .o_Tx_Serial(ser[2]), .o_Tx_Done(done[2]), .o_State(st[2])
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic exp_ser(input logic [7:0] b, input int c, input int k);
        if (k >= 1 && k <= c) return 1'b0;
        if (k > c && k <= 9 * c) return b[(k - 1) / c - 1];
        return 1'b1;
    endfunction

    function automatic state_t exp_st(input int c, input int k);
        if (k >= 1 && k <= c) return s_TX_START_BIT;
        if (k > c && k <= 9 * c) return s_TX_DATA_BITS;
        if (k > 9 * c && k <= 10 * c) return s_TX_STOP_BIT;
        if (k == 10 * c + 1) return s_CLEANUP;
        return s_IDLE;
    endfunction

    task automatic check_idle(input int d, input string tag);
        cmp({tag, " state"}, st[d], s_IDLE);
        cmp({tag, " serial"}, ser[d], 1'b1);
        cmp({tag, " done"}, done[d], 1'b0);
    endtask

    // Returns just after the accepting edge, i.e. inside cycle 1.
    task automatic start(input int d, input logic [7:0] b);
        @(negedge clk);
        dv[d]  = 1'b1;
        txb[d] = b;
        @(posedge clk);
        #1;
        dv[d]  = 1'b0;
        txb[d] = ~b;
    endtask

    task automatic frame_check(input int d, input logic [7:0] b, input int c,
                               input string tag, input int pulse_at);
        for (int k = 1; k <= 10 * c + 2; k++) begin
            @(negedge clk);
            cmp($sformatf("%s serial cyc%0d", tag, k), ser[d], exp_ser(b, c, k));
            cmp($sformatf("%s done cyc%0d", tag, k), done[d], (k == 10 * c + 1));
            cmp($sformatf("%s state cyc%0d", tag, k), st[d], exp_st(c, k));
            if (pulse_at > 0 && k == pulse_at) begin
                dv[d]  = 1'b1;
                txb[d] = 8'h3C;
            end else if (pulse_at > 0 && k == pulse_at + 1) begin
                dv[d]  = 1'b0;
                txb[d] = ~b;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vi;
        clk   = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dv[i]  = 1'b0;
            txb[i] = 8'h00;
        end

        // Hand-computed waveform for 0xA5 at CLKS_PER_BIT = 4 (bits LSB first: 1,0,1,0,0,1,0,1).
        vecs.push_back('{1,  1'b0, 1'b0, s_TX_START_BIT});
        vecs.push_back('{4,  1'b0, 1'b0, s_TX_START_BIT});
        vecs.push_back('{5,  1'b1, 1'b0, s_TX_DATA_BITS});
        vecs.push_back('{8,  1'b1, 1'b0, s_TX_DATA_BITS});
        vecs.push_back('{9,  1'b0, 1'b0, s_TX_DATA_BITS});
        vecs.push_back('{12, 1'b0, 1'b0, s_TX_DATA_BITS});
        vecs.push_back('{13, 1'b1, 1'b0, s_TX_DATA_BITS});
        vecs.push_back('{17, 1'b0, 1'b0, s_TX_DATA_BITS});
        vecs.push_back('{21, 1'b0, 1'b0, s_TX_DATA_BITS});
        vecs.push_back('{24, 1'b0, 1'b0, s_TX_DATA_BITS});
        vecs.push_back('{25, 1'b1, 1'b0, s_TX_DATA_BITS});
        vecs.push_back('{29, 1'b0, 1'b0, s_TX_DATA_BITS});
        vecs.push_back('{33, 1'b1, 1'b0, s_TX_DATA_BITS});
        vecs.push_back('{36, 1'b1, 1'b0, s_TX_DATA_BITS});
        vecs.push_back('{37, 1'b1, 1'b0, s_TX_STOP_BIT});
        vecs.push_back('{40, 1'b1, 1'b0, s_TX_STOP_BIT});
        vecs.push_back('{41, 1'b1, 1'b1, s_CLEANUP});
        vecs.push_back('{42, 1'b1, 1'b0, s_IDLE});

        // Reset state
        #12;
        for (int d = 0; d < 3; d++) check_idle(d, $sformatf("reset dut%0d", d));
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check_idle(0, "post-reset idle");
        end

        // Single byte 0xA5 against the table
        start(0, 8'hA5);
        vi = 0;
        for (int k = 1; k <= 42; k++) begin
            @(negedge clk);
            cmp($sformatf("A5 done-only-41 cyc%0d", k), done[0], (k == 41));
            while (vi < vecs.size() && vecs[vi].cyc == k) begin
                cmp($sformatf("A5 vec serial cyc%0d", k), ser[0], vecs[vi].ser);
                cmp($sformatf("A5 vec done cyc%0d", k), done[0], vecs[vi].done);
                cmp($sformatf("A5 vec state cyc%0d", k), st[0], vecs[vi].st);
                vi++;
            end
        end
        cmp("A5 table consumed", vi, vecs.size());

        // Back-to-back: 0x00 then 0xFF accepted in the idle cycle 42
        start(0, 8'h00);
        frame_check(0, 8'h00, C0, "b2b first", 0);
        dv[0]  = 1'b1;
        txb[0] = 8'hFF;
        @(posedge clk);
        #1;
        dv[0]  = 1'b0;
        txb[0] = 8'h00;
        frame_check(0, 8'hFF, C0, "b2b second", 0);

        // DV pulsed mid-frame must be ignored
        start(0, 8'h81);
        frame_check(0, 8'h81, C0, "ignored-dv", 10);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            check_idle(0, "ignored-dv no 2nd frame");
        end

        // Asynchronous reset in the middle of cycle 20
        start(0, 8'hE7);
        repeat (19) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle(0, "midframe async reset");
        @(posedge clk);
        #1;
        check_idle(0, "midframe reset held");
        @(negedge clk);
        rst_n = 1'b1;
        start(0, 8'h5A);
        frame_check(0, 8'h5A, C0, "after-reset 5A", 0);

        // Parameter sweep
        start(1, 8'hC3);
        frame_check(1, 8'hC3, C1, "sweep c2", 0);
        start(2, 8'hC3);
        frame_check(2, 8'hC3, C2, "sweep c87", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
